muladd: RTL and testbench

Sequential multiply-accumulate computing `num = quot * den + rem` over unsigned WIDTH-bit operands: the inverse of the `divmod` divider. It is used to rebuild a dividend from a quotient/remainder pair, and as a self-check partner for `divmod` in the primality pipeline. It uses the same go/ready/error handshake as `divmod`, so the two blocks can be swapped behind a common controller. Latency depends on the data: one add per set bit of `quot`, with zero bits skipped through a priority encoder.

---
 rtl/muladd_pkg.sv | 11 +
 rtl/prio_enc.sv | 19 +
 rtl/muladd.sv | 99 +++++++++
 tb/tb_muladd.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/muladd_pkg.sv
// muladd shared types: FSM state encoding.
// Encoding matches divmod so a common controller can drive either.
package muladd_pkg;

  typedef enum logic [1:0] {
    ST_READY = 2'd0,
    ST_ADD   = 2'd1,
    ST_ERROR = 2'd2
  } state_t;

endpackage

// File: rtl/prio_enc.sv
// Priority encoder: index of the highest set bit, 0 when none.
// Shared with divmod; msb is a fixed 8-bit index.
module prio_enc #(
  parameter int WIDTH_LOG = 4
) (
  input  logic [(1<<WIDTH_LOG)-1:0] in,
  output logic [7:0]                msb
);

  localparam int W = 1 << WIDTH_LOG;

  always_comb begin
    msb = '0;
    for (int i = 0; i < W; i++) begin
      if (in[i]) msb = 8'(i);
    end
  end

endmodule

// File: rtl/muladd.sv
// Sequential multiply-accumulate: num = quot * den + rem.
// One shifted add per set bit of quot; go/ready/error like divmod.
module muladd
  import muladd_pkg::*;
#(
  parameter int WIDTH_LOG = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      go,
  input  logic [(1<<WIDTH_LOG)-1:0] quot,
  input  logic [(1<<WIDTH_LOG)-1:0] den,
  input  logic [(1<<WIDTH_LOG)-1:0] rem,
  output logic                      ready,
  output logic                      error,
  output logic [(1<<WIDTH_LOG)-1:0] num
);

  localparam int W  = 1 << WIDTH_LOG;
  localparam int W2 = 2 * W;

  state_t         state_q, state_d;
  logic [W2-1:0]  acc_q, acc_d;
  logic [W-1:0]   mreg_q, mreg_d;
  logic [W-1:0]   num_q, num_d;
  logic           ready_q, ready_d;
  logic           error_q, error_d;

  logic [7:0]     msb;
  logic [W2-1:0]  den_ext;
  logic [W2-1:0]  addend;
  logic [W2-1:0]  sum;
  logic [W-1:0]   one_hot;

  prio_enc #(
    .WIDTH_LOG (WIDTH_LOG)
  ) u_prio_enc (
    .in  (mreg_q),
    .msb (msb)
  );

  assign den_ext = {{W{1'b0}}, den};
  assign addend  = den_ext << msb;
  assign sum     = acc_q + addend;
  assign one_hot = {{(W-1){1'b0}}, 1'b1} << msb;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    mreg_d  = mreg_q;
    num_d   = num_q;
    unique case (state_q)
      ST_READY, ST_ERROR: begin
        if (go) begin
          state_d = ST_ADD;
          acc_d   = {{W{1'b0}}, rem};
          mreg_d  = quot;
        end
      end
      ST_ADD: begin
        if (mreg_q != '0) begin
          acc_d  = sum;
          mreg_d = mreg_q & ~one_hot;
        end else begin
          num_d = acc_q[W-1:0];
          // high half nonzero means the result does not fit in W bits
          if (acc_q[W2-1:W] == '0) state_d = ST_READY;
          else                     state_d = ST_ERROR;
        end
      end
      default: state_d = ST_READY;
    endcase
    ready_d = (state_d != ST_ADD);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_READY;
      acc_q   <= '0;
      mreg_q  <= '0;
      num_q   <= '0;
      ready_q <= 1'b1;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      mreg_q  <= mreg_d;
      num_q   <= num_d;
      ready_q <= ready_d;
      error_q <= error_d;
    end
  end

  assign ready = ready_q;
  assign error = error_q;
  assign num   = num_q;

endmodule

// File: tb/tb_muladd.sv
// Testbench for muladd: vector table, corner sequences, and a
// divide/rebuild round trip, checked through an expectation queue.
module tb_muladd;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         go;
  logic [W-1:0] quot, den, rem;
  logic         ready, error;
  logic [W-1:0] num;

  muladd #(.WIDTH_LOG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .go    (go),
    .quot  (quot),
    .den   (den),
    .rem   (rem),
    .ready (ready),
    .error (error),
    .num   (num)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] num;
    logic         err;
    logic         chk_num;
    int           busy;
  } exp_t;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] d;
    logic [W-1:0] r;
    logic [W-1:0] num;
    logic         err;
    int           busy;
  } vec_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic start_op(input logic [W-1:0] q, input logic [W-1:0] d,
                          input logic [W-1:0] r, input logic [W-1:0] en,
                          input logic ee, input logic cn, input bit hold);
    exp_t e;
    @(negedge clk);
    quot = q;
    den  = d;
    rem  = r;
    go   = 1'b1;
    e.num = en;
    e.err = ee;
    e.chk_num = cn;
    e.busy = $countones(q) + 1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    check("accept_ready_low", {31'd0, ready}, 32'd0);
    if (!hold) go = 1'b0;
  endtask

  task automatic wait_done();
    int   busy;
    exp_t e;
    busy = 1;
    while (!ready && busy <= 40) begin
      @(posedge clk);
      #1;
      if (!ready) busy++;
    end
    if (!ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout: ready still low after %0d cycles", busy);
    end
    if (sb.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard: completion with no expectation queued");
    end else begin
      e = sb.pop_front();
      check("busy_cycles", busy, e.busy);
      check("error", {31'd0, error}, {31'd0, e.err});
      if (e.chk_num) check("num", {16'd0, num}, {16'd0, e.num});
    end
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{q:16'd7,    d:16'd3,    r:16'd2,    num:16'd23,   err:1'b0, busy:4};
    vecs[1] = '{q:16'd0,    d:16'd1234, r:16'd55,   num:16'd55,   err:1'b0, busy:1};
    vecs[2] = '{q:16'h00FF, d:16'h0101, r:16'h0000, num:16'hFFFF, err:1'b0, busy:9};
    vecs[3] = '{q:16'h8000, d:16'h0001, r:16'h7FFF, num:16'hFFFF, err:1'b0, busy:2};
    vecs[4] = '{q:16'd3,    d:16'd0,    r:16'd9,    num:16'd9,    err:1'b0, busy:3};
    vecs[5] = '{q:16'h0100, d:16'h0100, r:16'h0000, num:16'h0000, err:1'b1, busy:2};
    vecs[6] = '{q:16'hFFFF, d:16'hFFFF, r:16'hFFFF, num:16'h0000, err:1'b1, busy:17};
    vecs[7] = '{q:16'd2,    d:16'd5,    r:16'd1,    num:16'd11,   err:1'b0, busy:2};

    rst_n = 1'b0;
    go    = 1'b1;
    quot  = 16'd5;
    den   = 16'd5;
    rem   = 16'd5;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", {31'd0, ready}, 32'd1);
    check("reset_error", {31'd0, error}, 32'd0);
    check("reset_num", {16'd0, num}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    go    = 1'b0;
    @(posedge clk);
    #1;
    check("idle_after_reset", {31'd0, ready}, 32'd1);

    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].q, vecs[i].d, vecs[i].r, vecs[i].num,
               vecs[i].err, !vecs[i].err, 1'b0);
      check("table_busy", $countones(vecs[i].q) + 1, vecs[i].busy);
      wait_done();
      check("done_ready", {31'd0, ready}, 32'd1);
    end

    // go held high: one gap cycle, then a second start
    start_op(16'hFFFF, 16'd1, 16'd0, 16'hFFFF, 1'b0, 1'b1, 1'b1);
    wait_done();
    begin
      exp_t e2;
      e2.num = 16'hFFFF;
      e2.err = 1'b0;
      e2.chk_num = 1'b1;
      e2.busy = 17;
      sb.push_back(e2);
    end
    @(posedge clk);
    #1;
    check("hold_go_restart", {31'd0, ready}, 32'd0);
    go = 1'b0;
    wait_done();

    // overflow, then ERROR state must accept go
    start_op(16'h1000, 16'h0010, 16'd0, 16'd0, 1'b1, 1'b0, 1'b0);
    wait_done();
    check("ovf_ready", {31'd0, ready}, 32'd1);
    start_op(16'd2, 16'd5, 16'd1, 16'd11, 1'b0, 1'b1, 1'b0);
    wait_done();

    // reset on the 5th busy cycle
    @(negedge clk);
    quot = 16'hFFFF;
    den  = 16'hFFFF;
    rem  = 16'd0;
    go   = 1'b1;
    @(posedge clk);
    #1;
    go = 1'b0;
    check("mid_busy", {31'd0, ready}, 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_ready", {31'd0, ready}, 32'd1);
    check("midrst_error", {31'd0, error}, 32'd0);
    check("midrst_num", {16'd0, num}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_stays_idle", {31'd0, ready}, 32'd1);

    // round trip against a division of random operands
    for (int k = 0; k < 1000; k++) begin
      logic [W-1:0] n, d, q, r;
      n = W'($urandom);
      d = W'($urandom_range(1, 65535));
      q = n / d;
      r = n % d;
      start_op(q, d, r, n, 1'b0, 1'b1, 1'b0);
      wait_done();
    end

    check("scoreboard_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
